// File: rtl/arm7_control_sequencer.sv
// ============================================================================
// Module   : arm7_control_sequencer (with package arm7_seq_pkg)
// Purpose  : Multi-cycle instruction sequencer for the ARM7 datapath. It
//            accepts one instruction at a time and drives one control word
//            per cycle to the register bank, shifter, B bus, address, ALU
//            and memory blocks. It covers data-processing and LDR/STR. Every
//            other class runs as a 1-cycle NOP and pulses undef.
// Ports    : clk, rst_n (async, active-low)
//            instr_valid/instr/instr_ready : instruction hand-off
//            cond_pass : condition result for IR[31:28], comb, external
//            mem_ready : memory completes the current access
//            control   : packed control_t word (see arm7_seq_pkg)
//            busy, undef, stall_count (only with ARM7_SEQ_PERF_CNT_EN)
// Options  : `define ARM7_SEQ_PERF_CNT_EN adds the saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm7_seq_pkg;
  typedef enum logic [1:0] {
    ADDR_NONE = 2'd0, ADDR_PC = 2'd1, ADDR_ALU = 2'd2, ADDR_INCR = 2'd3
  } addr_src_t;

  typedef enum logic [2:0] {
    B_NONE = 3'd0, B_IMM = 3'd1, B_REG_RM = 3'd2, B_REG_RS = 3'd3,
    B_REG_RD = 3'd4, B_READ_DATA = 3'd5
  } b_src_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0, SH_IMM = 2'd1, SH_REG = 2'd2
  } shift_src_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0, WB_REG_RD = 2'd1, WB_REG_RN = 2'd2
  } wb_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  typedef struct packed {
    addr_src_t  addr_bus_src;
    logic       incrementer_writeback;
    b_src_t     B_bus_src;
    logic [11:0] B_bus_imm;
    shift_src_t shift_source;
    logic [1:0] shift_type;
    logic [4:0] shift_amount;
    logic       latch_shift_amt;
    logic       use_shift_latch;
    logic [3:0] ALU_op;
    logic       ALU_disable_op_b;
    logic       set_ALU_flags;
    wb_t        alu_writeback;
    logic       memory_write_en;
  } control_t;

  localparam int CONTROL_W = $bits(control_t);
endpackage

module arm7_control_sequencer
  import arm7_seq_pkg::*;
#(
  parameter int PERF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  output logic                 instr_ready,
  input  logic                 cond_pass,
  input  logic                 mem_ready,
  output logic [CONTROL_W-1:0] control,
  output logic                 busy,
  output logic                 undef
`ifdef ARM7_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_SHLATCH = 3'd2,
    S_ADDR    = 3'd3,
    S_DATA    = 3'd4,
    S_LDWB    = 3'd5,
    S_POSTWB  = 3'd6,
    S_NOP     = 3'd7
  } state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_ir;
  logic        r_first;     // current cycle is the first of an instruction
  control_t    w_ctrl;
  logic        w_last;
  logic        w_undef;
  logic        w_accept;
  logic [3:0]  w_sdt_op;

  // Decode the entry state straight from the incoming word.
  function automatic state_t entry_state(input logic [31:0] w);
    state_t s;
    if (w[27:26] == 2'b00 && !(!w[25] && w[7] && w[4]))
      s = (!w[25] && w[4]) ? S_SHLATCH : S_EXEC;
    else if (w[27:26] == 2'b01 && !(w[25] && w[4]))
      s = S_ADDR;
    else
      s = S_NOP;
    return s;
  endfunction

  // Second operand: 12-bit immediate or Rm shifted by a 5-bit immediate.
  function automatic control_t with_op2(input control_t c, input logic use_imm,
                                        input logic [11:0] f);
    control_t r;
    r = c;
    if (use_imm) begin
      r.B_bus_src = B_IMM;
      r.B_bus_imm = f;
    end else begin
      r.B_bus_src    = B_REG_RM;
      r.shift_source = SH_IMM;
      r.shift_type   = f[6:5];
      r.shift_amount = f[11:7];
    end
    return r;
  endfunction

  assign w_sdt_op = r_ir[23] ? ALU_ADD : ALU_SUB;

  always_comb begin
    w_ctrl       = '0;
    w_next_state = r_state;
    w_last       = 1'b0;
    w_undef      = 1'b0;
    instr_ready  = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      S_SHLATCH: begin
        w_ctrl.B_bus_src             = B_REG_RS;
        w_ctrl.latch_shift_amt       = 1'b1;
        w_ctrl.addr_bus_src          = ADDR_PC;
        w_ctrl.incrementer_writeback = 1'b1;
        w_next_state                 = S_EXEC;
      end
      S_EXEC: begin
        w_ctrl               = with_op2(w_ctrl, r_ir[25], r_ir[11:0]);
        w_ctrl.ALU_op        = r_ir[24:21];
        w_ctrl.set_ALU_flags = r_ir[20];
        // TST/TEQ/CMP/CMN only update flags
        w_ctrl.alu_writeback = (r_ir[24:23] == 2'b10) ? WB_NONE : WB_REG_RD;
        if (!r_ir[25] && r_ir[4]) begin
          // PC already advanced during the shift-latch cycle
          w_ctrl.shift_source    = SH_REG;
          w_ctrl.use_shift_latch = 1'b1;
        end else begin
          w_ctrl.addr_bus_src          = ADDR_PC;
          w_ctrl.incrementer_writeback = 1'b1;
        end
        w_last = 1'b1;
      end
      S_ADDR: begin
        // SDT immediate offset is I=0, the opposite sense to data-processing
        w_ctrl                       = with_op2(w_ctrl, !r_ir[25], r_ir[11:0]);
        w_ctrl.ALU_op                = w_sdt_op;
        w_ctrl.addr_bus_src          = ADDR_ALU;
        w_ctrl.incrementer_writeback = 1'b1;
        if (!r_ir[24])
          w_ctrl.ALU_disable_op_b = 1'b1;       // post-index: address is Rn
        else if (r_ir[21])
          w_ctrl.alu_writeback    = WB_REG_RN;  // pre-index with write-back
        w_next_state = S_DATA;
      end
      S_DATA: begin
        if (!r_ir[20]) begin
          w_ctrl.B_bus_src       = B_REG_RD;
          w_ctrl.memory_write_en = 1'b1;
        end
        if (mem_ready) begin
          if (r_ir[20])      w_next_state = S_LDWB;
          else if (r_ir[24]) w_last       = 1'b1;
          else               w_next_state = S_POSTWB;
        end
      end
      S_LDWB: begin
        w_ctrl.B_bus_src     = B_READ_DATA;
        w_ctrl.ALU_op        = ALU_MOV;
        w_ctrl.alu_writeback = WB_REG_RD;
        if (r_ir[24]) w_last       = 1'b1;
        else          w_next_state = S_POSTWB;
      end
      S_POSTWB: begin
        w_ctrl               = with_op2(w_ctrl, !r_ir[25], r_ir[11:0]);
        w_ctrl.ALU_op        = w_sdt_op;
        w_ctrl.alu_writeback = WB_REG_RN;
        w_last               = 1'b1;
      end
      S_NOP: begin
        w_ctrl.addr_bus_src          = ADDR_PC;
        w_ctrl.incrementer_writeback = 1'b1;
        w_undef                      = 1'b1;
        w_last                       = 1'b1;
      end
      default: ;
    endcase

    // Failed condition: advance PC only, regardless of instruction class.
    if (r_first && !cond_pass) begin
      w_ctrl                       = '0;
      w_ctrl.addr_bus_src          = ADDR_PC;
      w_ctrl.incrementer_writeback = 1'b1;
      w_undef                      = 1'b0;
      w_last                       = 1'b1;
    end

    instr_ready = (r_state == S_IDLE) || w_last;
    w_accept    = instr_valid && instr_ready;
    if (instr_ready)
      w_next_state = w_accept ? entry_state(instr) : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_first <= w_accept;
      if (w_accept) r_ir <= instr;
    end
  end

  assign control = w_ctrl;
  assign busy    = (r_state != S_IDLE);
  assign undef   = w_undef;

  // Condition and register-index fields are consumed elsewhere in the datapath.
  logic w_unused_ir;
  assign w_unused_ir = ^{r_ir[31:26], r_ir[19:12]};

`ifdef ARM7_SEQ_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (r_state == S_DATA && !mem_ready && r_stall_count != '1)
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign stall_count = r_stall_count;
`else
  logic [31:0] w_unused_perf_w;
  assign w_unused_perf_w = PERF_CNT_W;
`endif

endmodule

`default_nettype wire
